// File: rtl/mem_access_stage.sv
// MEM pipeline stage: executes loads/stores over a ready-handshaked data bus,
// stalls upstream while an access is in flight and drives the MEM/WB fields.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        mem_stall,
    output logic [31:0] mem_write_data,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_misaligned,
    output logic        mem_bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    // Undefined encodings (011, 110, 111) fall into the word bucket.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_B:    store_be = 4'b0001 << a;
            SZ_H:    store_be = 4'b0011 << a;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    store_wdata = {4{d[7:0]}};
            SZ_H:    store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (size_of(f3))
            SZ_B:    load_extend = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    load_extend = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = rd;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [31:0]       addr_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [4:0]        rd_r;
    logic              reg_write_r;
    logic [2:0]        funct3_r;
    logic [31:0]       result_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              abort_r;

    logic              accept_s;
    logic              ready_hit_s;
    logic              timeout_s;
    logic [1:0]        size_s;
    logic              mem_op_s;
    logic              misaligned_s;

    assign size_s       = size_of(ex_funct3);
    assign mem_op_s     = ex_mem_read | ex_mem_write;
    assign misaligned_s = ((size_s == SZ_H) && ex_alu_result[0]) ||
                          ((size_s == SZ_W) && (ex_alu_result[1:0] != 2'b00));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Access context, timeout counter, load result and abort flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r      <= 32'd0;
            we_r        <= 1'b0;
            be_r        <= 4'd0;
            wdata_r     <= 32'd0;
            rd_r        <= 5'd0;
            reg_write_r <= 1'b0;
            funct3_r    <= 3'd0;
            result_r    <= 32'd0;
            cnt_r       <= '0;
            abort_r     <= 1'b0;
        end else if (accept_s) begin
            addr_r      <= ex_alu_result;
            we_r        <= ex_mem_write;
            be_r        <= ex_mem_write ? store_be(size_s, ex_alu_result[1:0]) : 4'b1111;
            wdata_r     <= ex_mem_write ? store_wdata(size_s, ex_store_data) : 32'd0;
            rd_r        <= ex_rd;
            reg_write_r <= ex_reg_write;
            funct3_r    <= ex_funct3;
            result_r    <= 32'd0;
            cnt_r       <= '0;
            abort_r     <= 1'b0;
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (ready_hit_s) begin
                result_r <= load_extend(funct3_r, addr_r[1:0], dmem_rdata);
            end else if (timeout_s) begin
                abort_r <= 1'b1;
            end
        end else if (state_r == DONE) begin
            abort_r <= 1'b0;
        end
    end

    // Next state and all outputs; an asserted reset forces every output low.
    always_comb begin
        state_s        = state_r;
        accept_s       = 1'b0;
        ready_hit_s    = 1'b0;
        timeout_s      = 1'b0;
        mem_stall      = 1'b0;
        mem_write_data = 32'd0;
        mem_rd         = 5'd0;
        mem_reg_write  = 1'b0;
        mem_misaligned = 1'b0;
        mem_bus_error  = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = 32'd0;
        dmem_be        = 4'd0;
        dmem_wdata     = 32'd0;
        if (!reset) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ex_valid && mem_op_s) begin
                        if (misaligned_s) begin
                            mem_misaligned = 1'b1;
                            state_s        = IDLE;
                        end else begin
                            mem_stall = 1'b1;
                            accept_s  = 1'b1;
                            state_s   = BUSY;
                        end
                    end else if (ex_valid) begin
                        mem_write_data = ex_alu_result;
                        mem_rd         = ex_rd;
                        mem_reg_write  = ex_reg_write;
                        state_s        = IDLE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BUSY: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_r;
                    dmem_addr  = {addr_r[31:2], 2'b00};
                    dmem_be    = be_r;
                    dmem_wdata = wdata_r;
                    mem_stall  = 1'b1;
                    if (dmem_ready) begin
                        ready_hit_s = 1'b1;
                        state_s     = DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == TIMEOUT_LIM)) begin
                        timeout_s = 1'b1;
                        state_s   = DONE;
                    end else begin
                        state_s = BUSY;
                    end
                end
                DONE: begin
                    mem_write_data = result_r;
                    mem_rd         = rd_r;
                    mem_reg_write  = reg_write_r & ~we_r & ~abort_r & (rd_r != 5'd0);
                    mem_bus_error  = abort_r;
                    state_s        = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized bench for mem_access_stage against an arithmetic
// reference model of byte lanes, extension and handshake timing.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        mem_stall;
    logic [31:0] mem_write_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_misaligned;
    logic        mem_bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    int tests = 0;
    int fails = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .mem_write_data(mem_write_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_misaligned(mem_misaligned),
        .mem_bus_error(mem_bus_error), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes from funct3.
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned v;
        int          n;
        int          sh;
        n  = nbytes(f3);
        sh = (n == 1) ? 8 * int'(addr[1:0]) : (n == 2) ? 16 * int'(addr[1]) : 0;
        v  = rdata >> sh;
        if (n == 1) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3,
                                            input logic [31:0] addr);
        int n;
        n = nbytes(f3);
        if (!st) return 4'hF;
        return 4'(((1 << n) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = nbytes(f3);
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    task automatic drive_op(input logic st, input logic both, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_alu_result = addr;
        ex_store_data = data;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_write  = st;
        ex_mem_read   = ~st | both;
        ex_funct3     = f3;
    endtask

    // One complete aligned access from the IDLE cycle through DONE.
    task automatic mem_op(input string tag, input logic st, input logic both,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic rw,
                          input int waits, input logic [31:0] rdata);
        logic exp_rw;
        exp_rw = !st && rw && (rd != 5'd0);
        drive_op(st, both, f3, addr, data, rd, rw);
        #1;
        chk({tag, " idle stall"}, 32'(mem_stall), 32'd1);
        chk({tag, " idle reg_write"}, 32'(mem_reg_write), 32'd0);
        chk({tag, " idle req"}, 32'(dmem_req), 32'd0);
        tick();
        for (int w = 0; w <= waits; w++) begin
            dmem_ready = (w == waits);
            dmem_rdata = (w == waits) ? rdata : $urandom;
            #1;
            chk({tag, " busy req"}, 32'(dmem_req), 32'd1);
            chk({tag, " busy stall"}, 32'(mem_stall), 32'd1);
            chk({tag, " busy we"}, 32'(dmem_we), 32'(st));
            chk({tag, " busy addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, " busy be"}, 32'(dmem_be), 32'(model_be(st, f3, addr)));
            if (st) chk({tag, " busy wdata"}, dmem_wdata, model_wdata(f3, data));
            tick();
        end
        dmem_ready = 1'($urandom_range(0, 1));
        #1;
        chk({tag, " done stall"}, 32'(mem_stall), 32'd0);
        chk({tag, " done reg_write"}, 32'(mem_reg_write), 32'(exp_rw));
        chk({tag, " done rd"}, 32'(mem_rd), 32'(rd));
        chk({tag, " done bus_error"}, 32'(mem_bus_error), 32'd0);
        if (!st) chk({tag, " done data"}, mem_write_data, model_load(f3, addr, rdata));
        tick();
        dmem_ready = 1'b0;
    endtask

    task automatic idle_step(input string tag);
        ex_valid      = 1'b0;
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
        ex_alu_result = $urandom;
        dmem_ready    = 1'($urandom_range(0, 1));
        #1;
        chk({tag, " idle-gap req"}, 32'(dmem_req), 32'd0);
        chk({tag, " idle-gap stall"}, 32'(mem_stall), 32'd0);
        chk({tag, " idle-gap reg_write"}, 32'(mem_reg_write), 32'd0);
        tick();
        dmem_ready = 1'b0;
    endtask

    logic [2:0]  f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        st;
    int          n;

    initial begin
        reset = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        drive_op(1'b0, 1'b0, 3'b010, 32'hDEAD_BEE0, 32'h0, 5'd3, 1'b1);
        ex_mem_read = 1'b0;
        #3;
        chk("reset write_data", mem_write_data, 32'd0);
        chk("reset reg_write", 32'(mem_reg_write), 32'd0);
        chk("reset rd", 32'(mem_rd), 32'd0);
        chk("reset stall", 32'(mem_stall), 32'd0);
        chk("reset req", 32'(dmem_req), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        dmem_ready = 1'b0;

        // Non-memory pass-through.
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        ex_mem_read = 1'b0;
        #1;
        chk("add data", mem_write_data, 32'h0000_1234);
        chk("add rd", 32'(mem_rd), 32'd5);
        chk("add reg_write", 32'(mem_reg_write), 32'd1);
        chk("add stall", 32'(mem_stall), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            ex_alu_result = $urandom;
            ex_rd         = 5'($urandom);
            ex_reg_write  = 1'($urandom_range(0, 1));
            #1;
            chk("alu data", mem_write_data, ex_alu_result);
            chk("alu reg_write", 32'(mem_reg_write), 32'(ex_reg_write));
            tick();
        end
        idle_step("post-alu");

        // Directed loads/stores, including back-to-back and read+write both set.
        mem_op("lb", 1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 0, 32'h80FF_0011);
        mem_op("sh", 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 1'b0, 3, 32'h0);
        mem_op("lhu", 1'b0, 1'b0, 3'b101, 32'h0000_0042, 32'h0, 5'd2, 1'b1, 1, 32'h9234_5678);
        mem_op("sb both", 1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 5'd4, 1'b1, 0, 32'h0);
        idle_step("post-sb");

        // Misaligned word load is suppressed without a bus request.
        drive_op(1'b0, 1'b0, 3'b010, 32'h0000_0001, 32'h0, 5'd6, 1'b1);
        #1;
        chk("mis lw pulse", 32'(mem_misaligned), 32'd1);
        chk("mis lw stall", 32'(mem_stall), 32'd0);
        chk("mis lw reg_write", 32'(mem_reg_write), 32'd0);
        chk("mis lw req", 32'(dmem_req), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("mis lw pulse end", 32'(mem_misaligned), 32'd0);
        chk("mis lw req later", 32'(dmem_req), 32'd0);
        tick();
        drive_op(1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'h1, 5'd0, 1'b0);
        #1;
        chk("mis sh pulse", 32'(mem_misaligned), 32'd1);
        tick();
        idle_step("post-mis");

        // Timeout: ready never comes.
        drive_op(1'b0, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 5'd8, 1'b1);
        tick();
        for (int w = 0; w < 4; w++) begin
            #1;
            chk("timeout req", 32'(dmem_req), 32'd1);
            chk("timeout bus_error early", 32'(mem_bus_error), 32'd0);
            tick();
        end
        #1;
        chk("timeout req drop", 32'(dmem_req), 32'd0);
        chk("timeout bus_error", 32'(mem_bus_error), 32'd1);
        chk("timeout reg_write", 32'(mem_reg_write), 32'd0);
        chk("timeout stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("timeout bus_error end", 32'(mem_bus_error), 32'd0);
        tick();

        // Reset asserted mid-access abandons it.
        drive_op(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd11, 1'b1);
        tick();
        #1;
        chk("rst busy req", 32'(dmem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst async req", 32'(dmem_req), 32'd0);
        chk("rst async stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ready = 1'b1;
        tick();
        #1;
        chk("rst hold reg_write", 32'(mem_reg_write), 32'd0);
        chk("rst hold bus_error", 32'(mem_bus_error), 32'd0);
        dmem_ready = 1'b0;
        reset = 1'b1;
        mem_op("lw rd0", 1'b0, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd0, 1'b1, 1, 32'h1357_9BDF);

        // Randomized aligned accesses.
        for (int i = 0; i < 40; i++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = st ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 7)];
            n    = nbytes(f3);
            addr = $urandom;
            addr = addr - (addr % 32'(n));
            data = $urandom;
            mem_op("rand", st, 1'($urandom_range(0, 1)) & st, f3, addr, data,
                   5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 1) == 1) idle_step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
